// File: rtl/uo_signature_capture.sv
// rtl/uo_signature_capture.sv - windowed 16-bit MISR signature and toggle count over the tile's uo_out bus
// Optional settle phase before capture: define UO_SETTLE_EN.
module uo_signature_capture #(
  parameter int              DATA_W        = 8,
  parameter int              SIG_W         = 16,
  parameter logic [SIG_W-1:0] SEED         = 16'hFFFF,
  parameter int              LEN_W         = 16,
  parameter int              SETTLE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  window_len,
  input  logic [DATA_W-1:0] tile_out,
  output logic              busy,
  output logic              done,
  output logic [SIG_W-1:0]  signature,
  output logic [LEN_W-1:0]  toggle_count
);

  if (SIG_W != 16 || DATA_W < 1 || DATA_W > 16 || SETTLE_CYCLES < 1) begin : g_bad_cfg
    $error("uo_signature_capture: unsupported parameter set");
  end

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_DONE    = 2'd2
`ifdef UO_SETTLE_EN
    , S_SETTLE = 2'd3
`endif
  } state_t;

  state_t            state_q, state_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [SIG_W-1:0]  sig_q, sig_d;
  logic [LEN_W-1:0]  tcnt_q, tcnt_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [DATA_W-1:0] prev_q, prev_d;

`ifdef UO_SETTLE_EN
  localparam int SCNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  logic [SCNT_W-1:0] scnt_q, scnt_d;
`endif

  logic             fb;
  logic [SIG_W-1:0] d_ext;

  assign fb    = sig_q[15] ^ sig_q[13] ^ sig_q[12] ^ sig_q[10];
  assign d_ext = SIG_W'(tile_out);

  always_comb begin
    state_d = state_q;
    sig_d   = sig_q;
    tcnt_d  = tcnt_q;
    rem_d   = rem_q;
    prev_d  = prev_q;
`ifdef UO_SETTLE_EN
    scnt_d  = scnt_q;
`endif

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          rem_d  = window_len;
          sig_d  = SEED;
          tcnt_d = '0;
          prev_d = tile_out;
          if (window_len == '0) begin
            state_d = S_DONE;
          end else begin
`ifdef UO_SETTLE_EN
            state_d = S_SETTLE;
            scnt_d  = SCNT_W'(SETTLE_CYCLES - 1);
`else
            state_d = S_CAPTURE;
`endif
          end
        end
      end
`ifdef UO_SETTLE_EN
      S_SETTLE: begin
        // Reference the first sample against what the tile shows once it has settled.
        if (scnt_q == '0) begin
          prev_d  = tile_out;
          state_d = S_CAPTURE;
        end else begin
          scnt_d = scnt_q - 1'b1;
        end
      end
`endif
      S_CAPTURE: begin
        sig_d = {sig_q[SIG_W-2:0], fb} ^ d_ext;
        if (tile_out != prev_q && tcnt_q != '1) begin
          tcnt_d = tcnt_q + 1'b1;
        end
        prev_d = tile_out;
        rem_d  = rem_q - 1'b1;
        if (rem_q == LEN_W'(1)) begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_CAPTURE);
`ifdef UO_SETTLE_EN
    if (state_d == S_SETTLE) begin
      busy_d = 1'b1;
    end
`endif
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sig_q   <= SEED;
      tcnt_q  <= '0;
      rem_q   <= '0;
      prev_q  <= '0;
`ifdef UO_SETTLE_EN
      scnt_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sig_q   <= sig_d;
      tcnt_q  <= tcnt_d;
      rem_q   <= rem_d;
      prev_q  <= prev_d;
`ifdef UO_SETTLE_EN
      scnt_q  <= scnt_d;
`endif
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign signature    = sig_q;
  assign toggle_count = tcnt_q;

endmodule

// File: doc/uo_signature_capture.md
Name: uo_signature_capture

Overview:
- Downstream stage for a microtile under test. Consumes the tile's 8-bit uo_out bus and compacts a programmable window of samples into a 16-bit MISR signature plus a toggle count.
- Lets silicon or bench checks compare one signature word instead of a full per-cycle trace.
- Sits between the tile's uo_out pins and the readout/scan logic. tile_out is synchronous to clk: the tile is driven by the same clock domain, so no synchronizer is needed.

Parameters:
- DATA_W, 8, width of tile_out; max 16.
- SIG_W, 16, MISR width. Fixed taps below; only 16 is supported.
- SEED, 16'hFFFF, MISR value loaded at start.
- LEN_W, 16, width of window_len and of the toggle counter.
- SETTLE_CYCLES, 4, settle delay. Used only when UO_SETTLE_EN is defined.

Ports:
- clk, input, 1, single clock; all state updates on the rising edge.
- rst, input, 1, synchronous, active-high reset.
- start, input, 1, one-cycle pulse; accepted in IDLE or DONE only.
- window_len, input, LEN_W, number of samples to compact; sampled on the accepted start.
- tile_out, input, DATA_W, the tile's uo_out bus.
- busy, output, 1, high in SETTLE and CAPTURE.
- done, output, 1, high in DONE.
- signature, output, SIG_W, current or final MISR value.
- toggle_count, output, LEN_W, samples that differed from the previous sample.

Behaviour:
- Reset (synchronous, any state): state=IDLE, busy=0, done=0, signature=SEED, toggle_count=0, remaining=0, prev=0.
- State machine: IDLE, SETTLE (optional), CAPTURE, DONE.
- start accepted in IDLE or DONE:
  - latch remaining=window_len, signature=SEED, toggle_count=0, prev=tile_out; done drops.
  - Next state is CAPTURE, or DONE if window_len==0 (signature stays SEED, count stays 0, done=1 after one edge).
- start during SETTLE or CAPTURE: ignored; no restart and no effect.
- CAPTURE, each edge, with d = zero-extended tile_out:
  - fb = sig[15]^sig[13]^sig[12]^sig[10]
  - sig_next = {sig[14:0], fb} ^ d
  - if tile_out != prev: toggle_count += 1, saturating at all-ones (no wrap)
  - prev = tile_out; remaining -= 1
  - when remaining==1 at the edge, next state is DONE.
- Latency: start accepted at edge 0; samples taken at edges 1..N; done=1 and busy=0 visible after edge N. Exactly N samples are compacted.
- DONE: signature and toggle_count hold until the next accepted start or rst. done stays high (level, not pulse).
- rst mid-CAPTURE: aborts the window; all outputs return to reset values on that edge.
- window_len=all-ones: 65535 samples, no overflow of remaining.

Optional Feature:
- Macro UO_SETTLE_EN.
- Defined:
  - accepted start (window_len!=0) enters SETTLE for exactly SETTLE_CYCLES edges.
  - busy=1 during SETTLE; no MISR or toggle updates.
  - prev is reloaded with tile_out on the last SETTLE edge, then CAPTURE begins.
  - total latency is N+SETTLE_CYCLES edges.
- Undefined: SETTLE state and its counter are absent; start goes directly to CAPTURE as above.

Test Plan:
- Reset values: rst=1 for 2 cycles with tile_out=0x5A -> busy=0, done=0, signature=0xFFFF, toggle_count=0.
- Single sample: start, window_len=1, tile_out=0xA5 constant, prev latched 0xA5 -> after 1 edge signature=0xFF5B, toggle_count=0, done=1.
- Zero data: window_len=1, tile_out=0x00 -> signature=0xFFFE, done after 1 edge.
- Toggles: window_len=4, prev latched 0x00, samples 0x01,0x01,0x02,0x00 -> toggle_count=3, done exactly 4 edges after start.
- Zero length and restart: window_len=0 -> done next edge, signature=0xFFFF. start again with window_len=2 from DONE -> done drops, rises 2 edges later.
- Abort and ignore: start with window_len=10; at sample 5 pulse start -> ignored. At sample 6 assert rst -> next edge busy=0, done=0, signature=0xFFFF. With UO_SETTLE_EN, window_len=1 -> done after 5 edges.
